mmio_bus_fabric: RTL and testbench

- Parametrised, sequential successor to the console's combinational MMIO address decode.
- Sits between the RV32 core data port and N memory-mapped slaves (RAM, keyboard, display, future timers/audio).
- Replaces fixed decode with per-slave base/mask windows, a valid/ready request handshake and variable-latency slave acks.
- Adds unmapped-address and timeout error responses, plus a saturating error counter.

---
 rtl/mmio_bus_fabric_if.sv | 36 +++
 rtl/mmio_bus_fabric.sv | 137 +++++++++++++
 tb/tb_mmio_bus_fabric.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mmio_bus_fabric_if.sv
// CPU-to-fabric request/response channel plus the shared slave-side bus.
// The fabric uses the slave modport; the requester/slave environment uses master.
interface mmio_bus_fabric_if #(
  parameter int N_SLAVES = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic [31:0]           req_addr;
  logic                  req_write;
  logic [31:0]           req_wdata;
  logic [3:0]            req_be;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic [N_SLAVES-1:0]   s_sel;
  logic [31:0]           s_addr;
  logic [31:0]           s_wdata;
  logic [3:0]            s_be;
  logic                  s_write;
  logic [N_SLAVES-1:0]   s_ack;
  logic [N_SLAVES*32-1:0] s_rdata;

  modport master (
    output req_valid, req_addr, req_write, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  s_sel, s_addr, s_wdata, s_be, s_write,
    output s_ack, s_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output s_sel, s_addr, s_wdata, s_be, s_write,
    input  s_ack, s_rdata
  );
endinterface

// File: rtl/mmio_bus_fabric.sv
// Sequential MMIO fabric: base/mask window decode, one outstanding transaction,
// variable-latency slave acks, unmapped/timeout error responses and an error counter.
module mmio_bus_fabric #(
  parameter int                   N_SLAVES       = 4,
  parameter logic [N_SLAVES*32-1:0] SLAVE_BASE   = {N_SLAVES{32'h0}},
  parameter logic [N_SLAVES*32-1:0] SLAVE_MASK   = {N_SLAVES{32'hFFFF_F000}},
  parameter int                   TIMEOUT_CYCLES = 16,
  parameter logic [31:0]          ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                clk,
  input  logic                reset_n,
  mmio_bus_fabric_if.slave    bus,
  output logic [7:0]          err_count
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q;
  logic [N_SLAVES-1:0] s_sel_q;
  logic [31:0]         s_addr_q;
  logic [31:0]         s_wdata_q;
  logic [3:0]          s_be_q;
  logic                s_write_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [31:0]         rsp_rdata_q;
  logic [7:0]          err_count_q;
  logic [31:0]         tmo_cnt_q;

  logic [N_SLAVES-1:0] hit_d;
  logic [31:0]         sel_rdata_d;
  logic [7:0]          err_count_d;
  logic                ack_d;
  logic                tmo_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Scan from the top index down so the lowest matching window ends up selected.
  always_comb begin
    hit_d = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((bus.req_addr & SLAVE_MASK[32*i +: 32]) ==
          (SLAVE_BASE[32*i +: 32] & SLAVE_MASK[32*i +: 32])) begin
        hit_d    = '0;
        hit_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_rdata_d = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (s_sel_q[i]) sel_rdata_d = bus.s_rdata[32*i +: 32];
    end
  end

  assign ack_d       = |(bus.s_ack & s_sel_q);
  assign tmo_d       = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));
  assign err_count_d = sat_inc8(err_count_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      s_sel_q     <= '0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      s_be_q      <= '0;
      s_write_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      err_count_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            s_addr_q  <= bus.req_addr;
            s_wdata_q <= bus.req_wdata;
            s_be_q    <= bus.req_be;
            s_write_q <= bus.req_write;
            tmo_cnt_q <= '0;
            if (|hit_d) begin
              s_sel_q <= hit_d;
              state_q <= ACCESS;
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= ERR_RDATA;
              err_count_q <= err_count_d;
            end
          end
        end
        ACCESS: begin
          // An ack arriving on the timeout cycle takes priority over the error.
          if (ack_d) begin
            s_sel_q     <= '0;
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= s_write_q ? 32'h0 : sel_rdata_d;
          end else if (tmo_d) begin
            s_sel_q     <= '0;
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= ERR_RDATA;
            err_count_q <= err_count_d;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 32'd1;
          end
        end
        RESP: begin
          state_q   <= IDLE;
          tmo_cnt_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.s_sel     = s_sel_q;
  assign bus.s_addr    = s_addr_q;
  assign bus.s_wdata   = s_wdata_q;
  assign bus.s_be      = s_be_q;
  assign bus.s_write   = s_write_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Randomized bench for mmio_bus_fabric: three-slave map, directed corner cases,
// saturation run and mid-access reset, checked against a window/latency model.
module tb_mmio_bus_fabric;
  localparam int NS  = 3;
  localparam int TMO = 16;

  logic       clk;
  logic       reset_n;
  logic [7:0] err_count;

  mmio_bus_fabric_if #(.N_SLAVES(NS)) bus ();

  mmio_bus_fabric #(
    .N_SLAVES      (NS),
    .SLAVE_BASE    ({32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .SLAVE_MASK    ({32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_F000}),
    .TIMEOUT_CYCLES(TMO),
    .ERR_RDATA     (32'hDEAD_BEEF)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] win_base [NS];
  logic [31:0] win_mask [NS];
  int          n_chk;
  int          n_fail;
  int          exp_errs;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_slave(input logic [31:0] addr);
    for (int i = 0; i < NS; i++)
      if ((addr & win_mask[i]) == (win_base[i] & win_mask[i])) return i;
    return -1;
  endfunction

  // k < 0 or k >= TMO means the selected slave never acks in time.
  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                         input logic [3:0] be, input int k, input logic [31:0] ack_data,
                         input bit spur);
    int          slv;
    int          resp_c;
    int          other;
    bit          exp_err;
    logic [2:0]  exp_sel;
    logic [31:0] exp_rdata;
    slv = ref_slave(addr);
    if (slv < 0) begin
      resp_c = 1; exp_err = 1'b1;
    end else if (k >= 0 && k < TMO) begin
      resp_c = 2 + k; exp_err = 1'b0;
    end else begin
      resp_c = TMO + 1; exp_err = 1'b1;
    end
    exp_rdata = exp_err ? 32'hDEAD_BEEF : (wr ? 32'h0 : ack_data);
    exp_sel   = (slv < 0) ? 3'b000 : 3'(1 << slv);
    if (exp_err) exp_errs = (exp_errs >= 255) ? 255 : exp_errs + 1;

    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_write = wr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    chk("req_ready_idle", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;

    for (int c = 1; c <= resp_c + 1; c++) begin
      bus.s_ack   = '0;
      bus.s_rdata = {$urandom, $urandom, $urandom};
      if (c <= resp_c) begin
        chk("rsp_valid", bus.rsp_valid, (c == resp_c) ? 1 : 0);
        chk("s_sel", bus.s_sel, (c < resp_c) ? exp_sel : 3'b000);
        chk("req_ready_busy", bus.req_ready, 0);
      end
      if (c == 1 && slv >= 0) begin
        chk("s_addr", bus.s_addr, addr);
        chk("s_wdata", bus.s_wdata, wdata);
        chk("s_write", bus.s_write, wr);
        chk("s_be", bus.s_be, be);
      end
      if (c == resp_c) begin
        chk("rsp_err", bus.rsp_err, exp_err);
        chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
      end
      if (c == resp_c + 1) begin
        chk("rsp_valid_low", bus.rsp_valid, 0);
        chk("req_ready_back", bus.req_ready, 1);
        chk("rsp_rdata_hold", bus.rsp_rdata, exp_rdata);
        chk("rsp_err_hold", bus.rsp_err, exp_err);
        chk("err_count", err_count, exp_errs);
      end
      if (slv >= 0 && k >= 0 && k < TMO && c == 1 + k) begin
        bus.s_ack[slv]            = 1'b1;
        bus.s_rdata[32*slv +: 32] = ack_data;
      end
      if (spur && slv >= 0 && c < resp_c && $urandom_range(0, 1) == 1) begin
        other = (slv + 1 + int'($urandom_range(0, 1))) % NS;
        bus.s_ack[other] = 1'b1;
      end
      if (c <= resp_c) begin
        @(posedge clk); #1;
      end
    end
    bus.s_ack  = '0;
    last_rdata = exp_rdata;
    last_err   = exp_err;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 4))
      0:       a = {20'h0, 12'($urandom)};
      1:       a = {24'h10_0000, 8'($urandom)};
      2:       a = {16'h2000, 16'($urandom)};
      3:       a = 32'h1000_0100 + 32'($urandom_range(0, 255));
      default: a = {4'($urandom_range(3, 15)), 28'($urandom)};
    endcase
    return a;
  endfunction

  initial begin
    n_chk = 0; n_fail = 0; exp_errs = 0;
    win_base[0] = 32'h0000_0000; win_mask[0] = 32'hFFFF_F000;
    win_base[1] = 32'h1000_0000; win_mask[1] = 32'hFFFF_FF00;
    win_base[2] = 32'h2000_0000; win_mask[2] = 32'hFFFF_0000;
    reset_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_write = 1'b0;
    bus.req_wdata = '0; bus.req_be = '0; bus.s_ack = '0; bus.s_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_s_sel", bus.s_sel, 0);
    chk("rst_s_addr", bus.s_addr, 0);
    chk("rst_s_write", bus.s_write, 0);
    chk("rst_err_count", err_count, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", bus.req_ready, 1);

    run_txn(32'h1000_0004, 1'b0, 32'h0, 4'hF, 0, 32'h1234_5678, 1'b0);
    run_txn(32'h2000_0010, 1'b1, 32'hCAFE_0001, 4'hF, 3, 32'h5555_AAAA, 1'b0);
    run_txn(32'h3000_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0);
    run_txn(32'h0000_0100, 1'b0, 32'h0, 4'h3, -1, 32'h0, 1'b0);
    run_txn(32'h0000_0100, 1'b0, 32'h0, 4'h3, TMO - 1, 32'h0BAD_F00D, 1'b0);
    run_txn(32'h0000_0200, 1'b0, 32'h0, 4'h1, 5, 32'h7777_0001, 1'b1);

    for (int n = 0; n < 60; n++) begin
      int k;
      k = $urandom_range(0, 19);
      run_txn(rand_addr(), 1'($urandom), $urandom, 4'($urandom), k, $urandom, 1'b1);
    end

    for (int n = 0; n < 300; n++)
      run_txn({4'($urandom_range(3, 15)), 28'($urandom)}, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0);
    chk("err_count_sat", err_count, 8'hFF);

    // Abort a transaction with reset while the slave is selected.
    bus.req_valid = 1'b1; bus.req_addr = 32'h0000_0040; bus.req_write = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_s_sel_pre", bus.s_sel, 3'b001);
    reset_n = 1'b0;
    #1;
    exp_errs = 0;
    chk("abort_s_sel", bus.s_sel, 0);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    chk("abort_err_count", err_count, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      chk("post_rst_rsp_valid", bus.rsp_valid, 0);
      chk("post_rst_req_ready", bus.req_ready, 1);
      chk("post_rst_s_sel", bus.s_sel, 0);
    end
    run_txn(32'h1000_0080, 1'b0, 32'h0, 4'hF, 2, 32'hA5A5_5A5A, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
